alu_sequencer: RTL and testbench

//  Fetch/decode/execute controller for the 16-bit accumulator ALU. Owns the accumulator,
//  PC and instruction register. Drives the ALU op selects (one-hot) and a single-port

---
 rtl/alu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator ALU.
// Owns acc, pc and ir; drives one-hot ALU op selects and a req/ack single-port memory.
module alu_sequencer #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              halted,
    output logic              error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       acc_data,
    output logic [15:0]       opnd_data,
    input  logic [15:0]       alu_result,
    input  logic              alu_is_zero,
    output logic              ctl_nad,
    output logic              ctl_shr,
    output logic              ctl_shl,
    output logic              ctl_read
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPND,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_NAD = 4'h1;
    localparam logic [3:0] OP_SHR = 4'h2;
    localparam logic [3:0] OP_SHL = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            next_state;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              mem_done;

    assign opcode   = ir[15:12];
    assign ir_addr  = ir[ADDR_W-1:0];
    assign mem_done = mem_req & mem_ack;
    assign halted   = (state == S_IDLE) || (state == S_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ctl_nad    = 1'b0;
        ctl_shr    = 1'b0;
        ctl_shl    = 1'b0;
        ctl_read   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) next_state = S_FETCH;
            end
            S_FETCH: begin
                if (mem_done) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_HLT:                 next_state = S_HALT;
                    OP_NAD:                 next_state = S_OPND;
                    OP_SHR, OP_SHL, OP_STA: next_state = S_EXEC;
                    OP_JZ, OP_JMP:          next_state = S_FETCH;
                    default:                next_state = S_HALT;
                endcase
            end
            S_OPND: begin
                if (mem_done) next_state = S_EXEC;
            end
            S_EXEC: begin
                next_state = S_FETCH;
                case (opcode)
                    OP_NAD: ctl_nad = 1'b1;
                    OP_SHR: ctl_shr = 1'b1;
                    OP_SHL: ctl_shl = 1'b1;
                    OP_STA: begin
                        ctl_read   = 1'b1;
                        next_state = S_STORE;
                    end
                    default: ;
                endcase
            end
            S_STORE: begin
                if (mem_done) next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Memory states raise req on their second cycle, so every access is preceded by an idle gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir        <= '0;
            acc_data  <= '0;
            opnd_data <= '0;
            error     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        ir      <= mem_rdata;
                        pc      <= pc + PC_ONE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_JZ:  if (alu_is_zero) pc <= ir_addr;
                        OP_JMP: pc <= ir_addr;
                        OP_HLT, OP_NAD, OP_SHR, OP_SHL, OP_STA: ;
                        default: error <= 1'b1;
                    endcase
                end
                S_OPND: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ir_addr;
                    end else if (mem_ack) begin
                        mem_req   <= 1'b0;
                        opnd_data <= mem_rdata;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_NAD, OP_SHR, OP_SHL: acc_data  <= alu_result;
                        OP_STA:                 mem_wdata <= alu_result;
                        default: ;
                    endcase
                end
                S_STORE: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= ir_addr;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected memory/ALU events,
// a negedge monitor acts as memory, pops and compares each observed event.
module tb_alu_sequencer;

    localparam int K_CTL   = 0;
    localparam int K_FETCH = 1;
    localparam int K_READ  = 2;
    localparam int K_STORE = 3;

    localparam logic [3:0] C_NAD  = 4'b1000;
    localparam logic [3:0] C_SHR  = 4'b0100;
    localparam logic [3:0] C_SHL  = 4'b0010;
    localparam logic [3:0] C_READ = 4'b0001;

    typedef struct {
        int          kind;
        logic        we;
        logic [11:0] addr;
        logic [15:0] data;
        logic [3:0]  ctl;
        int          gap;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halted;
    logic        error;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [15:0] acc_data;
    logic [15:0] opnd_data;
    logic [15:0] alu_result;
    logic        alu_is_zero;
    logic        ctl_nad;
    logic        ctl_shr;
    logic        ctl_shl;
    logic        ctl_read;

    logic [15:0] mem [0:4095];
    ev_t         sb[$];
    int          checks = 0;
    int          fails = 0;
    int          cycle = 0;
    int          last_fetch = 0;
    int          wait_cnt = -1;
    int          max_delay = 0;
    logic        hold_en = 1'b0;
    logic [11:0] hold_addr = 12'h000;
    logic        pending = 1'b0;
    logic [28:0] snap;

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halted      (halted),
        .error       (error),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .acc_data    (acc_data),
        .opnd_data   (opnd_data),
        .alu_result  (alu_result),
        .alu_is_zero (alu_is_zero),
        .ctl_nad     (ctl_nad),
        .ctl_shr     (ctl_shr),
        .ctl_shl     (ctl_shl),
        .ctl_read    (ctl_read)
    );

    always #5 clk = ~clk;

    // Reference ALU: the sequencer expects a combinational ALU around it.
    always_comb begin
        alu_result = 16'h0000;
        if (ctl_nad)       alu_result = ~(acc_data & opnd_data);
        else if (ctl_shr)  alu_result = acc_data >> 1;
        else if (ctl_shl)  alu_result = acc_data << 1;
        else if (ctl_read) alu_result = acc_data;
    end
    assign alu_is_zero = (acc_data == 16'h0000);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushEv(input int kind, input logic we, input logic [11:0] addr,
                          input logic [15:0] data, input logic [3:0] ctl, input int gap);
        ev_t e;
        e.kind = kind; e.we = we; e.addr = addr; e.data = data; e.ctl = ctl; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic expFetch(input logic [11:0] addr, input int gap);
        pushEv(K_FETCH, 1'b0, addr, 16'h0000, 4'b0000, gap);
    endtask

    task automatic expRead(input logic [11:0] addr);
        pushEv(K_READ, 1'b0, addr, 16'h0000, 4'b0000, -1);
    endtask

    task automatic expStore(input logic [11:0] addr, input logic [15:0] data);
        pushEv(K_STORE, 1'b1, addr, data, 4'b0000, -1);
    endtask

    task automatic expCtl(input logic [3:0] ctl, input logic [15:0] acc);
        pushEv(K_CTL, 1'b0, 12'h000, acc, ctl, -1);
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitHalted(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'b0, (n < budget)}, 32'd1);
    endtask

    // Program at 0..5: SHL, NAD 0x010, SHR, SHL, STA 0x020, HLT; timed adds zero-wait gaps.
    task automatic pushProgramA(input bit timed);
        expFetch(12'h000, -1);
        expCtl(C_SHL, 16'h0000);
        expFetch(12'h001, timed ? 4 : -1);
        expRead(12'h010);
        expCtl(C_NAD, 16'h0000);
        expFetch(12'h002, timed ? 6 : -1);
        expCtl(C_SHR, 16'hFFFF);
        expFetch(12'h003, timed ? 4 : -1);
        expCtl(C_SHL, 16'h7FFF);
        expFetch(12'h004, timed ? 4 : -1);
        expCtl(C_READ, 16'hFFFE);
        expStore(12'h020, 16'hFFFE);
        expFetch(12'h005, timed ? 6 : -1);
    endtask

    // Memory responder and scoreboard monitor; all DUT observation happens here.
    always @(negedge clk) begin
        ev_t         e;
        logic [3:0]  ctl_vec;
        cycle++;
        mem_ack = 1'b0;
        ctl_vec = {ctl_nad, ctl_shr, ctl_shl, ctl_read};
        if (ctl_vec != 4'b0000) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_ctl", {28'b0, ctl_vec}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("ctl_event_kind", K_CTL, e.kind);
                checkOutput("ctl_select", {28'b0, ctl_vec}, {28'b0, e.ctl});
                checkOutput("ctl_acc", {16'b0, acc_data}, {16'b0, e.data});
            end
        end
        if (mem_req === 1'b1) begin
            if (pending) checkOutput("req_stable", {3'b0, mem_we, mem_addr, mem_wdata}, {3'b0, snap});
            if (hold_en && mem_addr == hold_addr) begin
                pending = 1'b1;
                snap = {mem_we, mem_addr, mem_wdata};
            end else begin
                if (wait_cnt < 0) wait_cnt = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
                if (wait_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wait_cnt  = -1;
                    pending   = 1'b0;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_mem", {20'b0, mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("mem_event_is_ctl", {31'b0, (e.kind == K_CTL)}, 32'd0);
                        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                        checkOutput("mem_addr", {20'b0, mem_addr}, {20'b0, e.addr});
                        if (e.kind == K_STORE) checkOutput("mem_wdata", {16'b0, mem_wdata}, {16'b0, e.data});
                        if (e.gap >= 0) checkOutput("fetch_latency", cycle - last_fetch, e.gap);
                        if (e.kind == K_FETCH) last_fetch = cycle;
                    end
                end else begin
                    wait_cnt--;
                    pending = 1'b1;
                    snap = {mem_we, mem_addr, mem_wdata};
                end
            end
        end else begin
            pending  = 1'b0;
            wait_cnt = -1;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[0]      = 16'h3000;
        mem[1]      = 16'h1010;
        mem[2]      = 16'h2000;
        mem[3]      = 16'h3000;
        mem[4]      = 16'h4020;
        mem[5]      = 16'h0000;
        mem[6]      = 16'h1011;
        mem[7]      = 16'h5005;
        mem[8]      = 16'h2000;
        mem[9]      = 16'h5005;
        mem[12'h010] = 16'h00FF;
        mem[12'h011] = 16'hFFFF;

        repeat (2) @(negedge clk);
        checkOutput("rst_halted", {31'b0, halted}, 32'd1);
        checkOutput("rst_error", {31'b0, error}, 32'd0);
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
        checkOutput("rst_acc", {16'b0, acc_data}, 32'd0);
        checkOutput("rst_opnd", {16'b0, opnd_data}, 32'd0);
        checkOutput("rst_ctl", {28'b0, ctl_nad, ctl_shr, ctl_shl, ctl_read}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] zero-wait program: SHL NAD SHR SHL STA HLT");
        max_delay = 0;
        pushProgramA(1'b1);
        applyStimulus();
        waitHalted("halt_a_timeout", 200);
        checkOutput("acc_after_a", {16'b0, acc_data}, 32'h0000_FFFE);
        checkOutput("sb_empty_a", sb.size(), 32'd0);

        $display("[TB] same program with random ack delays");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("acc_cleared_b", {16'b0, acc_data}, 32'd0);
        max_delay = 5;
        pushProgramA(1'b0);
        applyStimulus();
        waitHalted("halt_b_timeout", 500);
        checkOutput("acc_after_b", {16'b0, acc_data}, 32'h0000_FFFE);
        checkOutput("sb_empty_b", sb.size(), 32'd0);

        $display("[TB] JZ not taken then taken, resume after HLT");
        max_delay = 0;
        expFetch(12'h006, -1);
        expRead(12'h011);
        expCtl(C_NAD, 16'hFFFE);
        expFetch(12'h007, 6);
        expFetch(12'h008, 3);
        expCtl(C_SHR, 16'h0001);
        expFetch(12'h009, 4);
        expFetch(12'h005, 3);
        applyStimulus();
        waitHalted("halt_c_timeout", 200);
        checkOutput("acc_after_c", {16'b0, acc_data}, 32'd0);
        checkOutput("error_after_c", {31'b0, error}, 32'd0);
        checkOutput("sb_empty_c", sb.size(), 32'd0);

        $display("[TB] JMP to illegal opcode");
        mem[6]       = 16'h6030;
        mem[12'h030] = 16'h9000;
        mem[12'h031] = 16'h1040;
        expFetch(12'h006, -1);
        expFetch(12'h030, 3);
        applyStimulus();
        waitHalted("halt_d_timeout", 200);
        checkOutput("error_set", {31'b0, error}, 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("no_req_after_error", {31'b0, mem_req}, 32'd0);
        checkOutput("halted_after_error", {31'b0, halted}, 32'd1);
        checkOutput("sb_empty_d", sb.size(), 32'd0);

        $display("[TB] reset during stalled operand read");
        hold_addr = 12'h040;
        hold_en   = 1'b1;
        expFetch(12'h031, -1);
        applyStimulus();
        n = 0;
        while (!(mem_req && mem_addr == 12'h040) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("opnd_req_seen", {31'b0, (n < 100)}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("opnd_req_held", {31'b0, mem_req}, 32'd1);
        checkOutput("error_sticky", {31'b0, error}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_req", {31'b0, mem_req}, 32'd0);
        checkOutput("midrst_error", {31'b0, error}, 32'd0);
        checkOutput("midrst_halted", {31'b0, halted}, 32'd1);
        checkOutput("midrst_addr", {20'b0, mem_addr}, 32'd0);
        checkOutput("midrst_opnd", {16'b0, opnd_data}, 32'd0);
        rst_n   = 1'b1;
        hold_en = 1'b0;
        mem[0]  = 16'h0000;
        expFetch(12'h000, -1);
        applyStimulus();
        waitHalted("halt_e_timeout", 200);
        checkOutput("sb_empty_e", sb.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
